// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Oversample tick divider, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restartable via clr.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled 3-sample majority vote, optional parity,
// 1-2 stop bits, valid/rdy handshake with parity/framing/overrun flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_t     PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rdy,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 perr,
  output logic                 ferr,
  output logic                 oerr
);

  localparam int unsigned   DIV      = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned   TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] SMP_A    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] SMP_B    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] SMP_C    = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);
  localparam logic          ODD_INV  = (PARITY == PAR_ODD);

  rx_state_t r_state, w_state_nxt;

  logic [1:0]           r_sync;
  logic                 r_rx_d;
  logic [TW-1:0]        r_tick_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_pend, r_ferr_pend;
  logic                 r_valid, r_perr, r_ferr, r_oerr;
  logic [DATA_BITS-1:0] r_data;

  logic w_rx, w_fall, w_tick, w_maj, w_par_bad;
  logic w_smp_a, w_smp_b, w_smp_c, w_bit_end;
  logic w_start, w_commit, w_clr, w_tcnt_clr, w_bit_clr, w_bit_inc;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_rx      = r_sync[1];
  assign w_fall    = r_rx_d & ~w_rx;
  assign w_smp_a   = w_tick && (r_tick_cnt == SMP_A);
  assign w_smp_b   = w_tick && (r_tick_cnt == SMP_B);
  assign w_smp_c   = w_tick && (r_tick_cnt == SMP_C);
  assign w_bit_end = w_tick && (r_tick_cnt == BIT_LAST);
  // Third sample is taken live from the synchroniser, so the vote resolves on that tick.
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_par_bad = w_maj ^ (^r_shift) ^ ODD_INV;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    w_clr       = 1'b0;
    w_tcnt_clr  = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tcnt_clr = 1'b1;
        w_bit_clr  = 1'b1;
        if (w_fall) begin
          w_state_nxt = START;
          w_start     = 1'b1;
          w_clr       = 1'b1;
        end
      end
      START: begin
        if (w_smp_c && w_maj) begin
          w_state_nxt = IDLE;
          w_tcnt_clr  = 1'b1;
        end else if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == DB_LAST) begin
            w_bit_clr   = 1'b1;
            w_state_nxt = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_smp_c && (r_bit_cnt == SB_LAST)) begin
          w_commit    = 1'b1;
          w_tcnt_clr  = 1'b1;
          w_bit_clr   = 1'b1;
          w_state_nxt = w_maj ? IDLE : BREAK;
        end else if (w_bit_end) begin
          w_bit_inc = 1'b1;
        end
      end
      BREAK: begin
        // Any low sample restarts the one-bit-time high qualification.
        if (!w_rx) begin
          w_clr      = 1'b1;
          w_tcnt_clr = 1'b1;
        end else if (w_bit_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= '1;
      r_rx_d      <= 1'b1;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_shift     <= '0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_rx_d <= w_rx;

      if (w_tcnt_clr) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= (r_tick_cnt == BIT_LAST) ? '0 : r_tick_cnt + 1'b1;
      end

      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_smp_a) r_s0 <= w_rx;
      if (w_smp_b) r_s1 <= w_rx;

      if ((r_state == DATA) && w_smp_c) begin
        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      end

      if (w_start) begin
        r_perr_pend <= 1'b0;
        r_ferr_pend <= 1'b0;
      end else begin
        if ((r_state == uart_pkg::PARITY) && w_smp_c && w_par_bad) r_perr_pend <= 1'b1;
        if ((r_state == STOP) && w_smp_c && !w_maj)                r_ferr_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_perr  <= r_perr_pend;
        r_ferr  <= r_ferr_pend | ~w_maj;
      end else if (r_valid && rdy) begin
        r_valid <= 1'b0;
      end

      // A handshake in the commit cycle means the old frame was consumed: no overrun.
      if (r_valid && rdy) begin
        r_oerr <= 1'b0;
      end else if (w_commit && r_valid) begin
        r_oerr <= 1'b1;
      end
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign perr  = r_perr;
  assign ferr  = r_ferr;
  assign oerr  = r_oerr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances at 64 clocks per bit.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 1_562_500;
  localparam int          BIT      = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rxd_v;
  logic [2:0] rdy_v;
  logic [2:0] valid_v, perr_v, ferr_v, oerr_v;
  logic [7:0] data0, data1, data2;

  int tests  = 0;
  int failed = 0;
  int vcnt   = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(PAR_NONE),
                .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .rdy(rdy_v[0]), .valid(valid_v[0]),
    .data(data0), .perr(perr_v[0]), .ferr(ferr_v[0]), .oerr(oerr_v[0]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(PAR_EVEN),
                .STOP_BITS(1), .OVERSAMPLE(16)) u1 (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .rdy(rdy_v[1]), .valid(valid_v[1]),
    .data(data1), .perr(perr_v[1]), .ferr(ferr_v[1]), .oerr(oerr_v[1]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(PAR_NONE),
                .STOP_BITS(2), .OVERSAMPLE(16)) u2 (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .rdy(rdy_v[2]), .valid(valid_v[2]),
    .data(data2), .perr(perr_v[2]), .ferr(ferr_v[2]), .oerr(oerr_v[2]));

  // Counts cycles in which u0 presents a frame.
  always @(negedge clk) if (valid_v[0] === 1'b1) vcnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic line(input int d, input logic v, input int n);
    rxd_v[d] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [7:0] b, input bit par_en, input logic pbit,
                      input int nstop, input logic [1:0] stops);
    line(d, 1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d, b[i], BIT);
    if (par_en) line(d, pbit, BIT);
    for (int i = 0; i < nstop; i++) line(d, stops[i], BIT);
    rxd_v[d] = stops[nstop-1];
  endtask

  task automatic ack(input int d);
    rdy_v[d] = 1'b1;
    @(negedge clk);
    rdy_v[d] = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    rxd_v = 3'b111;
    rdy_v = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_v), 32'h0);
    check("rst_data0", 32'(data0), 32'h0);
    check("rst_flags", 32'({perr_v, ferr_v, oerr_v}), 32'h0);
    check("rst_state", 32'(u0.r_state), 32'(IDLE));
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    check("idle_no_start", 32'(u0.r_state), 32'(IDLE));

    // 8N1 with rdy held high: one-cycle valid pulse
    rdy_v[0] = 1'b1;
    vcnt = 0;
    send(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01);
    repeat (4) @(negedge clk);
    check("8n1_pulse_cnt", 32'(vcnt), 32'd1);
    check("8n1_data", 32'(data0), 32'hA5);
    check("8n1_flags", 32'({perr_v[0], ferr_v[0], oerr_v[0]}), 32'h0);
    check("8n1_valid_low", 32'(valid_v[0]), 32'h0);
    rdy_v[0] = 1'b0;

    // 8E1: 0x3C has even weight, so parity bit 0 is correct
    send(1, 8'h3C, 1'b1, 1'b0, 1, 2'b01);
    check("8e1_valid", 32'(valid_v[1]), 32'h1);
    check("8e1_data", 32'(data1), 32'h3C);
    check("8e1_perr_ok", 32'(perr_v[1]), 32'h0);
    ack(1);
    check("8e1_ack", 32'(valid_v[1]), 32'h0);
    send(1, 8'h3C, 1'b1, 1'b1, 1, 2'b01);
    check("8e1_data_bad", 32'(data1), 32'h3C);
    check("8e1_perr_bad", 32'(perr_v[1]), 32'h1);
    check("8e1_oerr", 32'(oerr_v[1]), 32'h0);
    ack(1);

    // 8N2 with second stop bit low, then one idle bit and a clean frame
    rdy_v[2] = 1'b1;
    send(2, 8'h81, 1'b0, 1'b0, 2, 2'b01);
    check("8n2_data", 32'(data2), 32'h81);
    check("8n2_ferr", 32'(ferr_v[2]), 32'h1);
    check("8n2_break", 32'(u2.r_state), 32'(BREAK));
    line(2, 1'b1, BIT);
    send(2, 8'h42, 1'b0, 1'b0, 2, 2'b11);
    check("8n2_data2", 32'(data2), 32'h42);
    check("8n2_ferr2", 32'(ferr_v[2]), 32'h0);
    check("8n2_idle", 32'(u2.r_state), 32'(IDLE));

    // Overrun: two back-to-back frames without rdy
    send(0, 8'h11, 1'b0, 1'b0, 1, 2'b01);
    check("ovr_first", 32'({valid_v[0], oerr_v[0]}), 32'b10);
    send(0, 8'h22, 1'b0, 1'b0, 1, 2'b01);
    check("ovr_data", 32'(data0), 32'h22);
    check("ovr_valid", 32'(valid_v[0]), 32'h1);
    check("ovr_oerr", 32'(oerr_v[0]), 32'h1);
    ack(0);
    check("ovr_ack_valid", 32'(valid_v[0]), 32'h0);
    check("ovr_ack_oerr", 32'(oerr_v[0]), 32'h0);

    // Short low glitch: false start
    vcnt = 0;
    line(0, 1'b0, 20);
    line(0, 1'b1, 2 * BIT);
    check("glitch_no_valid", 32'(vcnt), 32'd0);
    check("glitch_idle", 32'(u0.r_state), 32'(IDLE));
    send(0, 8'h7E, 1'b0, 1'b0, 1, 2'b01);
    check("glitch_next_data", 32'(data0), 32'h7E);
    check("glitch_next_valid", 32'({valid_v[0], oerr_v[0]}), 32'b10);

    // Reset in the middle of the data bits
    line(0, 1'b0, BIT);
    line(0, 1'b1, BIT);
    line(0, 1'b0, BIT);
    line(0, 1'b1, BIT / 2);
    check("mid_state_data", 32'(u0.r_state), 32'(DATA));
    rst      = 1'b1;
    rxd_v[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(valid_v[0]), 32'h0);
    check("mid_rst_data", 32'(data0), 32'h0);
    check("mid_rst_state", 32'(u0.r_state), 32'(IDLE));
    rst = 1'b0;
    line(0, 1'b1, BIT);
    send(0, 8'h5A, 1'b0, 1'b0, 1, 2'b01);
    check("post_rst_data", 32'(data0), 32'h5A);
    check("post_rst_valid", 32'(valid_v[0]), 32'h1);
    check("post_rst_flags", 32'({perr_v[0], ferr_v[0], oerr_v[0]}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
